axi_read_master: RTL and testbench
==================================

AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI read-data width in bits; a multiple of 8.
REQ-002 Parameter ADDRESS_WIDTH, default 8: AXI address width in bits.
REQ-003 aclk  input  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_addr  input  ADDRESS_WIDTH  burst start byte address.
REQ-006 cmd_len  input  8  beats minus one (AXI encoding).
REQ-007 cmd_size  input  3  log2 bytes per beat; SHALL NOT exceed log2(DATA_WIDTH/8).
REQ-008 cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-009 araddr, arlen, arsize, arburst, arvalid  output  ADDRESS_WIDTH,8,3,2,1  AXI read-address channel; arready input 1.
REQ-010 rdata, rresp, rlast, rvalid  input  DATA_WIDTH,2,1,1  AXI read-data channel; rready output 1.
REQ-011 out_data, out_last, out_valid  output  DATA_WIDTH,1,1  downstream beat stream; out_ready input 1.
REQ-012 busy  output  1  high while a command is in progress.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 FSM states SHALL be IDLE, ADDR and DATA.
REQ-015 IDLE: cmd_ready=1; cmd_valid&cmd_ready SHALL capture addr/len/size and go to ADDR next cycle.
REQ-016 ADDR: arvalid=1, araddr/arlen/arsize = captured values, arburst=2'b01 (INCR); signals SHALL hold stable until arready.
REQ-017 arvalid&arready SHALL move the FSM to DATA and clear the beat counter (9 bits) to 0.
REQ-018 DATA: rready = not fifo_full; rready SHALL be 0 in IDLE and ADDR.
REQ-019 Each rvalid&rready SHALL push {rdata, last_flag} into a 2-entry FIFO and increment the beat counter; last_flag=1 when counter==captured len.
REQ-020 Accepting the beat with last_flag=1 SHALL return the FSM to IDLE on the next edge; a new command is accepted no earlier than that IDLE cycle.
REQ-021 FIFO head drives out_data/out_last; out_valid = not fifo_empty; pop on out_valid&out_ready.
REQ-022 Simultaneous push and pop on a full or non-empty FIFO SHALL keep occupancy unchanged and preserve order; no beat SHALL be lost or duplicated.
REQ-023 Minimum latency: a beat accepted at edge N SHALL appear on out_data after edge N (out_valid high in cycle N+1).
REQ-024 busy = (state != IDLE) or FIFO not empty.
REQ-025 err SHALL set on any accepted beat with rresp != 2'b00 and remain set until reset; data is still forwarded.
REQ-026 cmd_len=255 SHALL produce exactly 256 output beats, counter not wrapping before the last beat.

Reset
REQ-027 aresetn low SHALL immediately force state IDLE, FIFO empty, counter 0, err 0, arvalid 0, rready 0, out_valid 0, busy 0; cmd_ready becomes 1.
REQ-028 Reset mid-burst SHALL abandon the burst; remaining beats are not forwarded.
REQ-029 araddr/arlen/arsize, out_data and out_last reset to 0.

Configuration
REQ-030 Macro AXI_READ_MASTER_RLAST_CHECK_EN defined: err SHALL also set when an accepted beat's rlast differs from its last_flag.
REQ-031 Macro undefined: rlast SHALL be ignored; beat counting alone determines burst end.

Verification
REQ-032 Reset release, cmd addr=0x10 len=3 size=2, slave data 0x13121110..0x1F1E1D1C, out_ready=1 -> araddr=0x10 arlen=3 arburst=1; 4 beats out, out_last only on 4th, err=0.
REQ-033 len=0 command -> single beat with out_last=1; FSM back to IDLE; cmd_ready=1 the cycle after that beat.
REQ-034 out_ready=0 for 5 cycles during len=7 burst -> FIFO fills at 2, rready drops to 0, all 8 beats later delivered in order.
REQ-035 arready delayed 4 cycles -> arvalid and araddr stable throughout; no rready before handshake.
REQ-036 rresp=2'b10 on beat 2 of 4 -> err=1 from next cycle, stays 1; all 4 beats delivered; with macro, rlast=1 on beat 2 -> err=1.
REQ-037 aresetn pulsed low mid len=15 burst -> all outputs at reset values immediately; next command completes normally.

Source files
------------

// File: rtl/axi_read_master_if.sv
// Port bundle for axi_read_master: command input, AXI AR/R channels, downstream beat stream, status.
// master = the read engine, slave = the environment (command source, AXI slave, beat sink).
interface axi_read_master_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [7:0]               cmd_len;
  logic [2:0]               cmd_size;
  logic                     cmd_valid;
  logic                     cmd_ready;

  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;

  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  logic                     busy;
  logic                     err;

  modport master (
    input  cmd_addr, cmd_len, cmd_size, cmd_valid,
    output cmd_ready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output out_data, out_last, out_valid,
    input  out_ready,
    output busy, err
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_size, cmd_valid,
    input  cmd_ready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  out_data, out_last, out_valid,
    output out_ready,
    input  busy, err
  );
endinterface

// File: rtl/axi_read_master.sv
// Single-burst AXI INCR read master feeding a 2-deep beat FIFO; beats reach out_* one edge after acceptance, rready drops while the FIFO is full.
// Optional AXI_READ_MASTER_RLAST_CHECK_EN: also raise err when a beat's rlast disagrees with the counted last beat.
module axi_read_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_read_master_if.master axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [7:0]               r_len;
  logic [2:0]               r_size;
  logic [8:0]               r_cnt;
  logic                     r_err;

  logic [DATA_WIDTH-1:0]    r_fifo_dat [2];
  logic                     r_fifo_last [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_fifo_cnt;

  logic                     w_cmd_ready;
  logic                     w_arvalid;
  logic                     w_rready;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last_flag;
  logic                     w_beat_err;

  assign w_fifo_full  = (r_fifo_cnt == 2'd2);
  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign w_push       = axi.rvalid && w_rready;
  assign w_pop        = !w_fifo_empty && axi.out_ready;
  // 9-bit counter so a 256-beat burst compares against len=255 without wrapping
  assign w_last_flag  = (r_cnt == {1'b0, r_len});

`ifdef AXI_READ_MASTER_RLAST_CHECK_EN
  assign w_beat_err = (axi.rresp != 2'b00) || (axi.rlast != w_last_flag);
`else
  logic w_unused_rlast;
  assign w_unused_rlast = axi.rlast;
  assign w_beat_err     = (axi.rresp != 2'b00);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (axi.cmd_valid)          w_next_state = ADDR;
      ADDR:    if (axi.arready)            w_next_state = DATA;
      DATA:    if (w_push && w_last_flag)  w_next_state = IDLE;
      default:                             w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      IDLE:    w_cmd_ready = 1'b1;
      ADDR:    w_arvalid   = 1'b1;
      DATA:    w_rready    = !w_fifo_full;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
    end else if (w_cmd_ready && axi.cmd_valid) begin
      r_addr <= axi.cmd_addr;
      r_len  <= axi.cmd_len;
      r_size <= axi.cmd_size;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (w_arvalid && axi.arready) begin
      r_cnt <= '0;
    end else if (w_push) begin
      r_cnt <= r_cnt + 9'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err <= 1'b0;
    end else if (w_push && w_beat_err) begin
      r_err <= 1'b1;
    end
  end

  // rready already blocks pushes into a full FIFO, so push+pop only meets a non-full queue
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_fifo_dat[0]  <= '0;
      r_fifo_dat[1]  <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_fifo_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wr_ptr]  <= axi.rdata;
        r_fifo_last[r_wr_ptr] <= w_last_flag;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  assign axi.cmd_ready = w_cmd_ready;
  assign axi.araddr    = r_addr;
  assign axi.arlen     = r_len;
  assign axi.arsize    = r_size;
  assign axi.arburst   = 2'b01;
  assign axi.arvalid   = w_arvalid;
  assign axi.rready    = w_rready;
  assign axi.out_data  = r_fifo_dat[r_rd_ptr];
  assign axi.out_last  = r_fifo_last[r_rd_ptr];
  assign axi.out_valid = !w_fifo_empty;
  assign axi.busy      = (r_state != IDLE) || !w_fifo_empty;
  assign axi.err       = r_err;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed and randomized bursts against a queue-based model of the command/AXI/beat-stream rules.
module tb_axi_read_master;
  localparam int DW = 32;
  localparam int AW = 8;

  logic aclk = 1'b0;
  logic aresetn;
  int   vectors = 0;
  int   miscompares = 0;

  axi_read_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  axi_read_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (bus)
  );

  always #5 aclk = ~aclk;

  // model: beats accepted but not yet delivered, as {data, last}
  logic [32:0] q[$];
  bit          cmd_done;
  bit          ar_done;
  bit          err_exp;
  int          beats_acc;
  int          beats_out;
  logic [7:0]  exp_addr;
  logic [7:0]  exp_len;
  logic [2:0]  exp_size;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit          in_burst;
    bit          arv;
    logic [32:0] head;
    in_burst = cmd_done && (beats_acc <= int'(exp_len));
    arv      = cmd_done && !ar_done;
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(!in_burst));
    chk("arvalid",   64'(bus.arvalid),   64'(arv));
    if (arv) begin
      chk("araddr",  64'(bus.araddr),  64'(exp_addr));
      chk("arlen",   64'(bus.arlen),   64'(exp_len));
      chk("arsize",  64'(bus.arsize),  64'(exp_size));
      chk("arburst", 64'(bus.arburst), 64'(2'b01));
    end
    chk("rready",    64'(bus.rready),    64'(ar_done && in_burst && (q.size() < 2)));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      head = q[0];
      chk("out_data", 64'(bus.out_data), 64'(head[32:1]));
      chk("out_last", 64'(bus.out_last), 64'(head[0]));
    end
    chk("busy", 64'(bus.busy), 64'(in_burst || (q.size() > 0)));
    chk("err",  64'(bus.err),  64'(err_exp));
  endtask

  task automatic apply_reset();
    aresetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    q.delete();
    cmd_done  = 1'b0;
    ar_done   = 1'b0;
    err_exp   = 1'b0;
    beats_acc = 0;
    beats_out = 0;
    exp_len   = 8'd0;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_arvalid",   64'(bus.arvalid),   64'(0));
    chk("rst_rready",    64'(bus.rready),    64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    chk("rst_err",       64'(bus.err),       64'(0));
    chk("rst_araddr",    64'(bus.araddr),    64'(0));
    chk("rst_arlen",     64'(bus.arlen),     64'(0));
    chk("rst_arsize",    64'(bus.arsize),    64'(0));
    chk("rst_out_data",  64'(bus.out_data),  64'(0));
    chk("rst_out_last",  64'(bus.out_last),  64'(0));
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    check_outputs();
  endtask

  // One command end to end; sampling and driving both happen 1 time unit after each rising edge.
  task automatic run_burst(input logic [7:0] a, input logic [7:0] l, input logic [2:0] s,
                           input int ar_delay, input int bad_beat, input int lastflip_beat,
                           input int stall_at, input bit pattern, input int abort_at);
    int          cyc = 0;
    int          ar_wait = 0;
    int          data_cyc = 0;
    bit          pend = 1'b0;
    bit          do_cmd, do_ar, do_push, do_pop, bad, rl, lflag;
    logic [31:0] cur = '0;
    exp_addr  = a;
    exp_len   = l;
    exp_size  = s;
    cmd_done  = 1'b0;
    ar_done   = 1'b0;
    beats_acc = 0;
    beats_out = 0;
    while (!(cmd_done && beats_out == int'(l) + 1)) begin
      check_outputs();
      if (cyc >= 3000) begin
        chk("burst_timeout", 64'(beats_out), 64'(int'(l) + 1));
        return;
      end
      if (abort_at > 0 && ar_done && data_cyc == abort_at) begin
        apply_reset();
        return;
      end
      bus.cmd_valid = !cmd_done;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      bus.cmd_size  = s;
      bus.arready   = cmd_done && !ar_done && (ar_wait >= ar_delay);
      if (cmd_done && !ar_done) ar_wait++;
      if (!pend) begin
        pend = ar_done && (beats_acc <= int'(l)) && (stall_at >= 0 || $urandom_range(0, 3) != 0);
        cur  = pattern ? 32'h13121110 + 32'h04040404 * 32'(beats_acc) : $urandom;
      end
      lflag         = (beats_acc == int'(l));
      bad           = (beats_acc == bad_beat);
      rl            = lflag ^ (beats_acc == lastflip_beat);
      bus.rvalid    = pend;
      bus.rdata     = cur;
      bus.rresp     = bad ? 2'b10 : 2'b00;
      bus.rlast     = rl;
      if (stall_at >= 0 && data_cyc >= stall_at && data_cyc < stall_at + 5)
        bus.out_ready = 1'b0;
      else
        bus.out_ready = (pattern || stall_at >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      do_cmd  = bus.cmd_valid && !(cmd_done && beats_acc <= int'(l));
      do_ar   = bus.arready;
      do_push = pend && ar_done && (beats_acc <= int'(l)) && (q.size() < 2);
      do_pop  = bus.out_ready && (q.size() > 0);
      @(posedge aclk); #1;
      cyc++;
      if (ar_done) data_cyc++;
      if (do_cmd) cmd_done = 1'b1;
      if (do_ar)  ar_done  = 1'b1;
      if (do_pop) begin
        void'(q.pop_front());
        beats_out++;
      end
      if (do_push) begin
        q.push_back({cur, lflag});
        if (bad) err_exp = 1'b1;
`ifdef AXI_READ_MASTER_RLAST_CHECK_EN
        if (rl != lflag) err_exp = 1'b1;
`endif
        beats_acc++;
        pend = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rvalid    = 1'b0;
    bus.arready   = 1'b0;
    check_outputs();
  endtask

  initial begin
    aresetn       = 1'b1;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_size  = '0;
    bus.cmd_valid = 1'b0;
    bus.arready   = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
    bus.rvalid    = 1'b0;
    bus.out_ready = 1'b0;
    cmd_done      = 1'b0;
    ar_done       = 1'b0;
    err_exp       = 1'b0;
    beats_acc     = 0;
    beats_out     = 0;
    exp_len       = 8'd0;
    #2;
    apply_reset();

    run_burst(8'h10, 8'd3,  3'd2, 0, -1, -1, -1, 1'b1, 0);  // patterned 4-beat burst
    run_burst(8'h40, 8'd0,  3'd2, 0, -1, -1, -1, 1'b0, 0);  // single beat
    run_burst(8'h80, 8'd7,  3'd2, 0, -1, -1,  1, 1'b0, 0);  // downstream stall fills FIFO
    run_burst(8'hA4, 8'd3,  3'd1, 4, -1, -1, -1, 1'b0, 0);  // slow arready
    run_burst(8'h30, 8'd3,  3'd2, 0,  1, -1, -1, 1'b0, 0);  // SLVERR on beat 2
    run_burst(8'h34, 8'd2,  3'd0, 1, -1, -1, -1, 1'b0, 0);  // err stays sticky
    run_burst(8'h20, 8'd15, 3'd2, 0, -1, -1, -1, 1'b0, 6);  // reset mid-burst
    run_burst(8'h24, 8'd3,  3'd2, 0, -1, -1, -1, 1'b0, 0);
    run_burst(8'h50, 8'd3,  3'd2, 0, -1,  1, -1, 1'b0, 0);  // early rlast
    apply_reset();
    run_burst(8'h00, 8'd255, 3'd2, 0, -1, -1, -1, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] rl_len;
      int         rbad;
      rl_len = 8'($urandom_range(0, 20));
      rbad   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rl_len))) : -1;
      run_burst(8'($urandom), rl_len, 3'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                rbad, -1, -1, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
